// File: rtl/axis_packetizer_pkg.sv
// Shared types and default parameters for the AXI-Stream packetizer.
package axis_pkt_pkg;

  localparam int unsigned DEF_FIFO_WIDTH = 32;
  localparam int unsigned DEF_PKT_LEN    = 16;
  localparam int unsigned DEF_CNT_WIDTH  = 16;

  typedef enum logic {PAYLOAD, TRAILER} pkt_state_t;

endpackage

// File: rtl/axis_packetizer_out_reg.sv
// Single-entry AXI-Stream output register: holds valid/data/last until a handshake.
module axis_out_reg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  input  logic             tready,
  output logic             free,
  output logic             tvalid,
  output logic [WIDTH-1:0] tdata,
  output logic             tlast
);

  assign free = !tvalid || tready;

  always_ff @(posedge clk) begin
    if (rst) begin
      tvalid <= 1'b0;
      tdata  <= '0;
      tlast  <= 1'b0;
    end else if (load) begin
      tvalid <= 1'b1;
      tdata  <= load_data;
      tlast  <= load_last;
    end else if (free) begin
      // data/last are left as-is; only valid drops once the beat has gone
      tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_packetizer.sv
// Groups a continuous stream into PKT_LEN-beat packets, each closed by a
// checksum trailer (tlast) that makes the packet's modular sum zero.
module axis_packetizer
  import axis_pkt_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int unsigned PKT_LEN    = DEF_PKT_LEN,
  parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  axis_clk,
  input  logic                  axis_rst,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [FIFO_WIDTH-1:0] s_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [FIFO_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic [CNT_WIDTH-1:0]  pkt_count
);

  localparam int unsigned BEAT_W = $clog2(PKT_LEN + 1);

  pkt_state_t            state;
  logic [BEAT_W-1:0]     beat_cnt;
  logic [FIFO_WIDTH-1:0] sum;
  logic [FIFO_WIDTH-1:0] load_data;
  logic                  free;
  logic                  accept;
  logic                  trailer_load;
  logic                  load;
  logic                  load_last;

  assign s_axis_tready = (state == PAYLOAD) && free && !axis_rst;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign trailer_load  = (state == TRAILER) && free;

  always_comb begin
    load      = accept || trailer_load;
    load_last = trailer_load;
    load_data = s_axis_tdata;
    if (trailer_load) load_data = '0 - sum;
  end

  axis_out_reg #(
    .WIDTH (FIFO_WIDTH)
  ) u_out_reg (
    .clk       (axis_clk),
    .rst       (axis_rst),
    .load      (load),
    .load_data (load_data),
    .load_last (load_last),
    .tready    (m_axis_tready),
    .free      (free),
    .tvalid    (m_axis_tvalid),
    .tdata     (m_axis_tdata),
    .tlast     (m_axis_tlast)
  );

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      state     <= PAYLOAD;
      beat_cnt  <= '0;
      sum       <= '0;
      pkt_count <= '0;
    end else begin
      case (state)
        PAYLOAD: begin
          if (accept) begin
            sum      <= sum + s_axis_tdata;
            beat_cnt <= beat_cnt + BEAT_W'(1);
            if (beat_cnt == BEAT_W'(PKT_LEN - 1)) state <= TRAILER;
          end
        end
        TRAILER: begin
          if (free) begin
            sum       <= '0;
            beat_cnt  <= '0;
            pkt_count <= pkt_count + CNT_WIDTH'(1);
            state     <= PAYLOAD;
          end
        end
        default: state <= PAYLOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_packetizer.sv
// Scoreboard bench for axis_packetizer (PKT_LEN=4 main instance, PKT_LEN=1 corner instance).
module tb_axis_packetizer;

  localparam int unsigned PKT_LEN = 4;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic        axis_clk = 1'b0;
  logic        axis_rst = 1'b1;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [31:0] s_axis_tdata = '0;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic [15:0] pkt_count;

  logic        v1 = 1'b0;
  logic        r1;
  logic [31:0] d1 = '0;
  logic        mv1;
  logic        mr1 = 1'b1;
  logic [31:0] md1;
  logic        ml1;
  logic [15:0] pc1;

  int          checks = 0;
  int          errors = 0;
  beat_t       exp_q[$];
  logic [31:0] m_sum = '0;
  int unsigned m_beats = 0;
  logic [31:0] last_trailer = '0;

  always #5 axis_clk = ~axis_clk;

  axis_packetizer #(
    .FIFO_WIDTH (32),
    .PKT_LEN    (PKT_LEN),
    .CNT_WIDTH  (16)
  ) u_dut (
    .axis_clk      (axis_clk),
    .axis_rst      (axis_rst),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .pkt_count     (pkt_count)
  );

  axis_packetizer #(
    .FIFO_WIDTH (32),
    .PKT_LEN    (1),
    .CNT_WIDTH  (16)
  ) u_dut1 (
    .axis_clk      (axis_clk),
    .axis_rst      (axis_rst),
    .s_axis_tvalid (v1),
    .s_axis_tready (r1),
    .s_axis_tdata  (d1),
    .m_axis_tvalid (mv1),
    .m_axis_tready (mr1),
    .m_axis_tdata  (md1),
    .m_axis_tlast  (ml1),
    .pkt_count     (pc1)
  );

  // Reference model: every accepted beat is expected; each PKT_LEN-th adds a trailer.
  function automatic void model_accept(input logic [31:0] d);
    beat_t b;
    b.data = d;
    b.last = 1'b0;
    exp_q.push_back(b);
    m_sum = m_sum + d;
    m_beats++;
    if (m_beats == PKT_LEN) begin
      b.data = 32'd0 - m_sum;
      b.last = 1'b1;
      exp_q.push_back(b);
      m_sum   = '0;
      m_beats = 0;
    end
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_sum   = '0;
    m_beats = 0;
  endfunction

  always @(negedge axis_clk) begin : monitor
    beat_t e;
    if (!axis_rst && m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got data=%h last=%b, required no beat", m_axis_tdata, m_axis_tlast);
      end else begin
        e = exp_q.pop_front();
        if (m_axis_tdata !== e.data || m_axis_tlast !== e.last) begin
          errors++;
          $display("FAIL sb_beat got data=%h last=%b, required data=%h last=%b",
                   m_axis_tdata, m_axis_tlast, e.data, e.last);
        end
        if (e.last) last_trailer = m_axis_tdata;
      end
    end
  end

  task automatic send(input logic [31:0] d);
    bit done = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge axis_clk);
      if (s_axis_tready === 1'b1) begin
        model_accept(d);
        done = 1;
      end
      @(posedge axis_clk); #1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL send_timeout data=%h never accepted, required acceptance within 200 cycles", d);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
      @(posedge axis_clk); #1;
    end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout got %0d beats pending, required 0", exp_q.size());
    end
    @(posedge axis_clk); #1;
  endtask

  task automatic test_reset();
    axis_rst = 1'b1;
    repeat (3) @(posedge axis_clk);
    #1 axis_rst = 1'b0;
    @(posedge axis_clk); #1;
    checks += 5;
    if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %b required 0", m_axis_tvalid); end
    if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast got %b required 0", m_axis_tlast); end
    if (m_axis_tdata !== 32'd0) begin errors++; $display("FAIL rst_tdata got %h required 0", m_axis_tdata); end
    if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL rst_tready got %b required 1", s_axis_tready); end
    if (pkt_count !== 16'd0) begin errors++; $display("FAIL rst_pkt_count got %0d required 0", pkt_count); end
  endtask

  task automatic test_basic();
    m_axis_tready = 1'b1;
    for (int i = 1; i <= 4; i++) send(32'(i));
    s_axis_tvalid = 1'b0;
    @(negedge axis_clk);
    checks++;
    if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL basic_bubble got tready=%b required 0", s_axis_tready); end
    @(posedge axis_clk); #1;
    @(negedge axis_clk);
    checks++;
    if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL basic_bubble_end got tready=%b required 1", s_axis_tready); end
    drain();
    checks += 2;
    if (last_trailer !== 32'hFFFF_FFF6) begin errors++; $display("FAIL basic_trailer got %h required fffffff6", last_trailer); end
    if (pkt_count !== 16'd1) begin errors++; $display("FAIL basic_pkt_count got %0d required 1", pkt_count); end
  endtask

  task automatic test_backpressure();
    m_axis_tready = 1'b0;
    send(32'hA5A5_A5A5);
    s_axis_tdata = 32'h1111_1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge axis_clk);
      checks++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'hA5A5_A5A5 || s_axis_tready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold got valid=%b data=%h s_tready=%b required 1 a5a5a5a5 0",
                 m_axis_tvalid, m_axis_tdata, s_axis_tready);
      end
      @(posedge axis_clk); #1;
    end
    m_axis_tready = 1'b1;
    @(negedge axis_clk);
    checks++;
    if (s_axis_tready !== 1'b1) begin
      errors++; $display("FAIL bp_same_cycle got s_tready=%b required 1", s_axis_tready);
    end else model_accept(32'h1111_1111);
    @(posedge axis_clk); #1;
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h1111_1111) begin
      errors++; $display("FAIL bp_reload got valid=%b data=%h required 1 11111111", m_axis_tvalid, m_axis_tdata);
    end
    send(32'd3);
    send(32'd4);
    s_axis_tvalid = 1'b0;
    drain();
  endtask

  task automatic test_wrap();
    send(32'hFFFF_FFFF);
    send(32'h0000_0002);
    send(32'd0);
    send(32'd0);
    s_axis_tvalid = 1'b0;
    drain();
    checks++;
    if (last_trailer !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_trailer got %h required ffffffff", last_trailer); end
  endtask

  task automatic test_mid_reset();
    send(32'd9);
    send(32'd10);
    m_axis_tready = 1'b0;
    s_axis_tvalid = 1'b0;
    axis_rst = 1'b1;
    @(posedge axis_clk); #1;
    axis_rst = 1'b0;
    model_reset();
    checks += 2;
    if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL midrst_tvalid got %b required 0", m_axis_tvalid); end
    if (pkt_count !== 16'd0) begin errors++; $display("FAIL midrst_pkt_count got %0d required 0", pkt_count); end
    m_axis_tready = 1'b1;
    for (int i = 5; i <= 8; i++) send(32'(i));
    s_axis_tvalid = 1'b0;
    drain();
    checks += 2;
    if (last_trailer !== 32'hFFFF_FFE6) begin errors++; $display("FAIL midrst_trailer got %h required ffffffe6", last_trailer); end
    if (pkt_count !== 16'd1) begin errors++; $display("FAIL midrst_pkt_count_end got %0d required 1", pkt_count); end
  endtask

  task automatic test_back_to_back();
    int          hs = 0;
    int          w  = 0;
    logic [14:0] lastm = '0;
    m_axis_tready = 1'b1;
    fork
      begin
        for (int i = 0; i < 12; i++) send(32'h100 + 32'(i));
        s_axis_tvalid = 1'b0;
      end
      begin
        @(negedge axis_clk);
        while (m_axis_tvalid !== 1'b1 && w < 50) begin @(negedge axis_clk); w++; end
        for (int k = 0; k < 15; k++) begin
          if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) hs++;
          lastm[k] = m_axis_tlast;
          if (k < 14) @(negedge axis_clk);
        end
      end
    join
    drain();
    checks += 3;
    if (hs != 15) begin errors++; $display("FAIL tput_beats got %0d required 15", hs); end
    if (lastm !== 15'b100001000010000) begin errors++; $display("FAIL tput_tlast got %b required 100001000010000", lastm); end
    if (pkt_count !== 16'd4) begin errors++; $display("FAIL tput_pkt_count got %0d required 4", pkt_count); end
  endtask

  task automatic test_pkt_len1();
    v1 = 1'b1;
    d1 = 32'd7;
    @(negedge axis_clk);
    checks++;
    if (r1 !== 1'b1) begin errors++; $display("FAIL len1_tready got %b required 1", r1); end
    @(posedge axis_clk); #1;
    v1 = 1'b0;
    checks++;
    if (mv1 !== 1'b1 || md1 !== 32'd7 || ml1 !== 1'b0) begin
      errors++; $display("FAIL len1_payload got valid=%b data=%h last=%b required 1 00000007 0", mv1, md1, ml1);
    end
    @(posedge axis_clk); #1;
    checks += 2;
    if (mv1 !== 1'b1 || md1 !== 32'hFFFF_FFF9 || ml1 !== 1'b1) begin
      errors++; $display("FAIL len1_trailer got valid=%b data=%h last=%b required 1 fffffff9 1", mv1, md1, ml1);
    end
    if (pc1 !== 16'd1) begin errors++; $display("FAIL len1_pkt_count got %0d required 1", pc1); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_mid_reset();
    test_back_to_back();
    test_pkt_len1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
